// File: rtl/lif_pkg.sv
// lif_pkg: shared widths, rate-decoder state encoding and window-length helper
package lif_pkg;
  localparam int RATE_W = 8;
  localparam int MIN_WIN_LOG2 = 4;
  localparam int SEL_W = 3;
  localparam int TMR_W = MIN_WIN_LOG2 + 2 ** SEL_W - 1;
  typedef enum logic [1:0] {ST_IDLE, ST_COUNT, ST_DUMP} rate_state_t;
  function automatic logic [TMR_W:0] win_cycles(input logic [SEL_W-1:0] sel);
    return (TMR_W + 1)'(1) << (MIN_WIN_LOG2 + int'(sel));
  endfunction
endpackage

// File: rtl/lif_spike_rate_decoder_if.sv
// lif_spike_rate_decoder_if: spike/window inputs and rate outputs of the rate decoder
interface lif_spike_rate_decoder_if;
  import lif_pkg::*;
  logic ena;
  logic spike_in;
  logic [SEL_W-1:0] win_sel;
  logic [RATE_W-1:0] rate_out;
  logic rate_valid;
  logic sat_flag;
  logic busy;
  modport master (output ena, spike_in, win_sel, input rate_out, rate_valid, sat_flag, busy);
  modport slave (input ena, spike_in, win_sel, output rate_out, rate_valid, sat_flag, busy);
endinterface

// File: rtl/lif_spike_edge.sv
// lif_spike_edge: rising-edge pulse on d; clr pins history high so a held level never counts
module lif_spike_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic d,
  output logic rise
);
  logic prev;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) prev <= 1'b0;
    else prev <= clr | d;
  assign rise = d & ~prev & ~clr;
endmodule

// File: rtl/lif_spike_rate_decoder.sv
// lif_spike_rate_decoder: counts spike rising edges per 2^(MIN_WIN_LOG2+win_sel)-cycle window, publishes a saturating rate
module lif_spike_rate_decoder
  import lif_pkg::*;
(
  input logic clk,
  input logic rst_n,
  lif_spike_rate_decoder_if.slave bus
);
  rate_state_t state, state_d;
  logic [TMR_W-1:0] timer;
  logic [RATE_W-1:0] count, count_inc, rate_q;
  logic [SEL_W-1:0] win_len_q;
  logic sat_pend, sat_inc, sat_q, valid_q, rise, at_max, last;
  lif_spike_edge u_edge (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (state == ST_IDLE),
    .d    (bus.spike_in),
    .rise (rise)
  );
  assign at_max = &count;
  assign count_inc = count + RATE_W'(rise & ~at_max);
  assign sat_inc = sat_pend | (rise & at_max);
  assign last = timer == TMR_W'(win_cycles(win_len_q) - 1'b1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= ST_IDLE;
    else state <= state_d;
  always_comb begin
    state_d = state;
    if (!bus.ena) state_d = ST_IDLE;
    else if (state != ST_COUNT) state_d = ST_COUNT;
    else if (last) state_d = ST_DUMP;
  end
  // Results are registered on the terminal edge so they are visible during the DUMP cycle
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      timer <= '0;
      count <= '0;
      sat_pend <= 1'b0;
      win_len_q <= '0;
      rate_q <= '0;
      sat_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (!bus.ena) begin
        timer <= '0;
        count <= '0;
        sat_pend <= 1'b0;
      end else if (state != ST_COUNT) begin
        timer <= '0;
        count <= (state == ST_DUMP) ? RATE_W'(rise) : '0;
        sat_pend <= 1'b0;
        win_len_q <= bus.win_sel;
      end else if (last) begin
        rate_q <= count_inc;
        sat_q <= sat_inc;
        valid_q <= 1'b1;
        timer <= '0;
        count <= '0;
        sat_pend <= 1'b0;
      end else begin
        timer <= timer + 1'b1;
        count <= count_inc;
        sat_pend <= sat_inc;
      end
    end
  assign bus.rate_out = rate_q;
  assign bus.sat_flag = sat_q;
  assign bus.rate_valid = valid_q;
  assign bus.busy = state == ST_COUNT;
endmodule

// File: tb/tb_lif_spike_rate_decoder.sv
// tb_lif_spike_rate_decoder: random and directed spike streams against a window-level reference model
module tb_lif_spike_rate_decoder;
  import lif_pkg::*;
  typedef struct {int rate; int sat;} exp_t;
  typedef struct {int rate; int sat; int cyc;} obs_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  lif_spike_rate_decoder_if bus ();
  lif_spike_rate_decoder dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  int n_chk, n_fail, cyc, start_cyc;
  exp_t exp_q[$];
  obs_t got_q[$];
  exp_t sb_e;
  int m_mode, m_left, m_n, m_rate, m_sat;
  bit m_prev, m_e;

  task automatic chk(input string name, input int act, input int req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic expect_got(input string name, input int idx, input int rate, input int sat);
    if (got_q.size() <= idx) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s: window %0d missing, got %0d windows", name, idx, got_q.size());
    end else begin
      chk({name, "_rate"}, got_q[idx].rate, rate);
      chk({name, "_sat"}, got_q[idx].sat, sat);
    end
  endtask

  task automatic step(input logic s);
    bus.spike_in = s;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus.ena = 1'b0;
    repeat (n) step(1'b0);
  endtask

  task automatic start(input int sel);
    bus.win_sel = SEL_W'(sel);
    bus.ena = 1'b1;
    step(1'b0);
    start_cyc = cyc;
  endtask

  // n one-cycle pulses on odd steps, padded with low to len steps
  task automatic pulses(input int n, input int len);
    for (int i = 0; i < len; i++) step(i < 2 * n && i % 2 == 1);
  endtask

  always @(posedge clk) cyc++;

  // Reference model: windows of 2^(4+sel) counting cycles, one dump cycle between,
  // unbounded edge tally reported as min(n,255) with saturation when n exceeds 255
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m_mode = 0;
      m_prev = 1'b1;
      m_n = 0;
      m_rate = 0;
      m_sat = 0;
      exp_q.delete();
    end else begin
      m_e = m_mode != 0 && bus.spike_in && !m_prev;
      m_prev = m_mode == 0 || bus.spike_in;
      if (!bus.ena) m_mode = 0;
      else if (m_mode != 1) begin
        m_n = m_mode == 2 ? int'(m_e) : 0;
        m_left = 1 << (MIN_WIN_LOG2 + int'(bus.win_sel));
        m_mode = 1;
      end else begin
        m_n += int'(m_e);
        m_left--;
        if (m_left == 0) begin
          m_rate = m_n > 255 ? 255 : m_n;
          m_sat = m_n > 255 ? 1 : 0;
          exp_q.push_back('{m_rate, m_sat});
          m_mode = 2;
        end
      end
    end

  always @(negedge clk)
    if (rst_n) begin
      chk("busy", int'(bus.busy), int'(m_mode == 1));
      chk("rate_valid", int'(bus.rate_valid), int'(m_mode == 2));
      chk("rate_out_hold", int'(bus.rate_out), m_rate);
      chk("sat_flag_hold", int'(bus.sat_flag), m_sat);
      if (bus.rate_valid) begin
        got_q.push_back('{int'(bus.rate_out), int'(bus.sat_flag), cyc});
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL sb_unexpected: rate_valid with rate %0d, no window expected", bus.rate_out);
        end else begin
          sb_e = exp_q.pop_front();
          chk("sb_rate", int'(bus.rate_out), sb_e.rate);
          chk("sb_sat", int'(bus.sat_flag), sb_e.sat);
        end
      end
    end

  initial begin
    #2_000_000;
    n_fail++;
    $display("FAIL watchdog: run exceeded time limit");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    bus.ena = 1'b0;
    bus.spike_in = 1'b0;
    bus.win_sel = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_rate_out", int'(bus.rate_out), 0);
    chk("rst_rate_valid", int'(bus.rate_valid), 0);
    chk("rst_sat_flag", int'(bus.sat_flag), 0);
    chk("rst_busy", int'(bus.busy), 0);
    // five pulses in a 16-cycle window
    idle(2);
    got_q.delete();
    start(0);
    pulses(5, 16);
    step(1'b0);
    expect_got("t2", 0, 5, 0);
    if (got_q.size() > 0) chk("t2_latency", got_q[0].cyc - start_cyc, 16);
    chk("t2_count", got_q.size(), 1);
    // held level, terminal-cycle edge, dump-cycle edge
    idle(2);
    got_q.delete();
    start(0);
    step(1'b0);
    repeat (10) step(1'b1);
    repeat (4) step(1'b0);
    step(1'b1);
    step(1'b0);
    repeat (16) step(1'b0);
    step(1'b1);
    repeat (17) step(1'b0);
    expect_got("t3_w1", 0, 2, 0);
    expect_got("t3_w2", 1, 0, 0);
    expect_got("t3_w3", 2, 1, 0);
    // 256-cycle window at 128 edges, then saturating 2048-cycle window
    idle(2);
    got_q.delete();
    start(4);
    for (int i = 0; i < 257; i++) begin
      if (i == 100) bus.win_sel = 3'd7;
      step(i[0]);
    end
    for (int i = 0; i < 2049; i++) step(i[0]);
    expect_got("t4_w1", 0, 128, 0);
    expect_got("t4_w2", 1, 255, 1);
    // win_sel change mid-window only affects the next window
    idle(2);
    got_q.delete();
    start(0);
    repeat (4) step(1'b0);
    bus.win_sel = 3'd2;
    repeat (78) step(1'b0);
    chk("t5_count", got_q.size(), 2);
    if (got_q.size() > 1) begin
      chk("t5_win1_len", got_q[0].cyc - start_cyc, 16);
      chk("t5_win2_len", got_q[1].cyc - got_q[0].cyc, 65);
    end
    // ena drop mid-window discards the partial count
    idle(2);
    got_q.delete();
    start(0);
    pulses(5, 16);
    step(1'b0);
    pulses(3, 6);
    idle(3);
    chk("t6_busy", int'(bus.busy), 0);
    chk("t6_hold", int'(bus.rate_out), 5);
    start(0);
    pulses(3, 16);
    step(1'b0);
    expect_got("t6_w1", 0, 5, 0);
    expect_got("t6_w2", 1, 3, 0);
    chk("t6_count", got_q.size(), 2);
    // random stream with random window sizes and ena drops
    idle(2);
    start(0);
    for (int i = 0; i < 3000; i++) begin
      if (i % 97 == 0) bus.win_sel = SEL_W'($urandom_range(0, 4));
      if ($urandom_range(0, 199) == 0) bus.ena = 1'b0;
      else if (!bus.ena && $urandom_range(0, 2) == 0) bus.ena = 1'b1;
      step($urandom_range(0, 2) == 0 ? ~bus.spike_in : bus.spike_in);
    end
    idle(4);
    chk("sb_drain", exp_q.size(), 0);
    // asynchronous reset in the middle of a window
    got_q.delete();
    start(0);
    pulses(5, 16);
    step(1'b0);
    start(1);
    pulses(4, 10);
    #3 rst_n = 1'b0;
    bus.ena = 1'b0;
    #1;
    chk("t1_rate_out", int'(bus.rate_out), 0);
    chk("t1_rate_valid", int'(bus.rate_valid), 0);
    chk("t1_sat_flag", int'(bus.sat_flag), 0);
    chk("t1_busy", int'(bus.busy), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    got_q.delete();
    repeat (40) step(1'b0);
    chk("t1_no_valid", got_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
